// File: rtl/mfcc_pkg.sv
// Shared MFCC pipeline types and framing constants used by the frame
// scheduler and the window buffer.
package mfcc_pkg;

    localparam int MFCC_FRAME_SIZE = 400;
    localparam int MFCC_FRAME_MOVE = 160;

    typedef enum logic [1:0] {
        SCHED_IDLE = 2'd0,
        SCHED_FILL = 2'd1,
        SCHED_HOP  = 2'd2,
        SCHED_BUSY = 2'd3
    } mfcc_sched_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/mfcc_frame_scheduler.sv
// Frame-level sequencer: counts incoming samples, issues start_move once a
// frame (or hop) is available and the previous frame has finished.
module mfcc_frame_scheduler
    import mfcc_pkg::*;
#(
    parameter int FRAME_SIZE     = MFCC_FRAME_SIZE,
    parameter int FRAME_MOVE     = MFCC_FRAME_MOVE,
    parameter int BACKLOG_LIMIT  = 1024,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int FCNT_WIDTH     = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable_i,
    input  logic                               sample_valid_i,
    input  logic                               mfcc_done_i,
    input  logic                               clear_flags_i,
    output logic                               start_move_o,
    output logic                               busy_o,
    output logic [FCNT_WIDTH-1:0]              frame_count_o,
    output logic [$clog2(BACKLOG_LIMIT+1)-1:0] pending_o,
    output logic                               overrun_o,
    output logic [15:0]                        drop_count_o,
    output logic                               timeout_o
);

    localparam int PW = $clog2(BACKLOG_LIMIT + 1);
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [PW-1:0] LIMIT      = PW'(BACKLOG_LIMIT);
    localparam logic [PW-1:0] NEED_FIRST = PW'(FRAME_SIZE);
    localparam logic [PW-1:0] NEED_HOP   = PW'(FRAME_MOVE);
    localparam logic [WW-1:0] WDOG_LAST  = WW'(TIMEOUT_CYCLES - 1);

    mfcc_sched_state_t      r_state;
    logic [PW-1:0]          r_pending;
    logic [WW-1:0]          r_wdog;
    logic                   r_start;
    logic                   r_busy;
    logic                   r_overrun;
    logic                   r_timeout;
    logic [FCNT_WIDTH-1:0]  r_frames;
    logic [15:0]            r_drops;

    logic                   w_waiting;
    logic                   w_issue;
    logic                   w_flush;
    logic                   w_count;
    logic                   w_drop;
    logic                   w_expire;
    logic [PW-1:0]          w_need;
    logic [PW-1:0]          w_pend_next;

    // Samples keep counting while a frame is in flight even if the scheduler
    // has been disabled; the backlog is discarded when it falls back to IDLE.
    always_comb begin
        w_waiting   = (r_state == SCHED_FILL) || (r_state == SCHED_HOP);
        w_need      = (r_state == SCHED_FILL) ? NEED_FIRST : NEED_HOP;
        w_issue     = w_waiting && enable_i && (r_pending >= w_need);
        w_flush     = w_waiting && !enable_i;
        w_count     = sample_valid_i && (enable_i || (r_state == SCHED_BUSY));
        w_drop      = w_count && (r_pending == LIMIT) && !w_issue;
        w_expire    = (r_state == SCHED_BUSY) && !mfcc_done_i && (r_wdog == WDOG_LAST);
        w_pend_next = r_pending;
        if (w_flush) begin
            w_pend_next = '0;
        end else begin
            if (w_count && !w_drop) begin
                w_pend_next = w_pend_next + PW'(1);
            end
            if (w_issue) begin
                w_pend_next = w_pend_next - w_need;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= SCHED_IDLE;
            r_pending <= '0;
            r_wdog    <= '0;
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
            r_frames  <= '0;
            r_drops   <= '0;
        end else begin
            r_start   <= w_issue;
            r_pending <= w_pend_next;

            // A new event in the same cycle as a clear leaves the flag set.
            if (w_drop) begin
                r_overrun <= 1'b1;
                r_drops   <= clear_flags_i ? 16'd1 : sat_inc16(r_drops);
            end else if (clear_flags_i) begin
                r_overrun <= 1'b0;
                r_drops   <= '0;
            end
            if (w_expire) begin
                r_timeout <= 1'b1;
            end else if (clear_flags_i) begin
                r_timeout <= 1'b0;
            end

            case (r_state)
                SCHED_IDLE: begin
                    if (enable_i) begin
                        r_state <= SCHED_FILL;
                    end
                end
                SCHED_FILL, SCHED_HOP: begin
                    if (!enable_i) begin
                        r_state <= SCHED_IDLE;
                    end else if (w_issue) begin
                        r_state <= SCHED_BUSY;
                        r_busy  <= 1'b1;
                        r_wdog  <= '0;
                    end
                end
                SCHED_BUSY: begin
                    if (mfcc_done_i) begin
                        r_state  <= SCHED_HOP;
                        r_busy   <= 1'b0;
                        r_frames <= r_frames + FCNT_WIDTH'(1);
                    end else if (w_expire) begin
                        r_state <= SCHED_HOP;
                        r_busy  <= 1'b0;
                    end else begin
                        r_wdog <= r_wdog + WW'(1);
                    end
                end
                default: r_state <= SCHED_IDLE;
            endcase
        end
    end

    assign start_move_o  = r_start;
    assign busy_o        = r_busy;
    assign frame_count_o = r_frames;
    assign pending_o     = r_pending;
    assign overrun_o     = r_overrun;
    assign drop_count_o  = r_drops;
    assign timeout_o     = r_timeout;

endmodule
